hazard_fwd_ctrl: RTL
====================

Name: hazard_fwd_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage RISC-V pipeline.
- Tracks destination-register records for the EX, MEM and WB stages in its own pipeline.
- Drives the select lines of the ALU-operand forwarding muxes. Each 2-bit select feeds a cascade of two 2:1 muxes.
- Raises a load-use stall and a branch flush toward IF/ID. Sits beside the ID/EX pipeline register.

Parameters:
- REG_ADDR_W, 5: register-address width.
- CNT_W, 16: width of the performance counters. Used only when HAZ_PERF_CNT_EN is defined.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs1  input  REG_ADDR_W  ID source register 1.
- id_rs2  input  REG_ADDR_W  ID source register 2.
- id_use_rs2  input  1  ID instruction reads rs2 (R/S/B types).
- id_rd  input  REG_ADDR_W  ID destination register.
- id_regwrite  input  1  ID instruction writes rd.
- id_memread  input  1  ID instruction is a load.
- ex_branch_taken  input  1  branch/jump resolved taken in EX.
- stall  output  1  hold PC and IF/ID; insert bubble into EX.
- flush  output  1  squash IF/ID; insert bubble into EX.
- fwd_a_sel  output  2  EX operand A select: 00 regfile, 01 WB result, 10 MEM ALU result.
- fwd_b_sel  output  2  EX operand B select; same encoding as fwd_a_sel.
- stall_cnt  output  CNT_W  stall cycles. Present only with HAZ_PERF_CNT_EN.
- flush_cnt  output  CNT_W  flush events. Present only with HAZ_PERF_CNT_EN.

Behaviour:
- Stage records:
  - EX record: valid, rs1, rs2, use_rs2, rd, regwrite, memread.
  - MEM and WB records: valid, rd, regwrite.
- Reset: rst=1 at a clock edge clears all valid bits. Outputs are then stall=0, flush=0, fwd_a_sel=00, fwd_b_sel=00 (counters 0). Reset asserted mid-stall or mid-flush drops the pending bubble; no state survives.
- Pipeline advance, every edge when rst=0:
  - WB <= MEM; MEM <= EX.
  - EX <= ID inputs, with valid = id_valid & ~stall & ~flush.
  - When stall or flush is asserted, the EX record becomes a bubble (valid=0). The ID instruction is re-presented next cycle (stall) or discarded (flush).
- Effective branch: taken = ex_branch_taken & EX.valid. ex_branch_taken is ignored when EX is a bubble.
- flush = taken. Combinational, same cycle.
- stall = ~taken & id_valid & EX.valid & EX.memread & EX.rd!=0 & (EX.rd==id_rs1 | (id_use_rs2 & EX.rd==id_rs2)).
  - Flush has priority over stall.
  - A load-use stall lasts exactly 1 cycle. After the bubble the load is in MEM, so the dependent instruction cannot stall again on it.
- Forwarding, combinational from the registered records, zero latency:
  - fwd_a_sel = 10 if MEM.valid & MEM.regwrite & MEM.rd!=0 & MEM.rd==EX.rs1.
  - Otherwise fwd_a_sel = 01 if the same condition holds on the WB record.
  - Otherwise fwd_a_sel = 00.
  - fwd_b_sel uses the same rule with EX.rs2, and is additionally gated by EX.use_rs2.
  - MEM has priority over WB (younger producer wins).
  - rd==x0 never forwards.
  - With EX.valid=0, both selects are 00.
- A load in MEM never reaches the 10 path: the stall guarantees it is forwarded from WB (01).
- Selects 11 are never produced.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on each clock with stall=1.
  - flush_cnt increments on each clock with flush=1.
  - Both are CNT_W bits, saturate at all-ones (no wrap), and clear on rst.
- Undefined: ports and counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 2 cycles with id_valid=1 and random fields -> stall=0, flush=0, fwd_a_sel=00, fwd_b_sel=00 during and after reset.
- ALU dependency distance 1 and 2:
  - Sequence: ADD x5 (rd=5, regwrite=1), then SUB rs1=5, then OR rs1=5.
  - SUB in EX -> fwd_a_sel=10.
  - OR in EX -> fwd_a_sel=01.
  - stall stays 0 throughout.
- Load-use:
  - Sequence: LW x7 (memread=1), then ADD rs2=7 with use_rs2=1.
  - stall=1 for exactly one cycle and EX gets a bubble.
  - Next cycle, ADD in EX -> fwd_b_sel=01; stall_cnt=1 if the feature is enabled.
- x0 and use_rs2 gating:
  - LW x0, then ADD rs1=0 -> stall=0 and fwd_a_sel=00.
  - ADDI with rs2 field=7 and use_rs2=0 after LW x7 -> no stall.
- Priority:
  - Two back-to-back writers of x3, then a reader with rs1=3 -> fwd_a_sel=10, not 01.
- Flush:
  - Branch in EX with ex_branch_taken=1 while ID holds a valid instruction -> flush=1 that cycle.
  - Next cycle EX.valid=0: its rd is never forwarded and ex_branch_taken=1 is ignored.
  - flush_cnt increments by 1.

Source files
------------

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: load-use stall, branch flush, EX operand forwarding selects.
// Optional stall/flush performance counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_fwd_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  ex_branch_taken,
  output logic                  stall,
  output logic                  flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
`endif
);

  typedef enum logic [1:0] {
    SEL_RF  = 2'b00,
    SEL_WB  = 2'b01,
    SEL_MEM = 2'b10
  } fwd_sel_e;

  logic                  ex_valid, ex_use_rs2, ex_regwrite, ex_memread;
  logic [REG_ADDR_W-1:0] ex_rs1, ex_rs2, ex_rd;
  logic                  mem_valid, mem_regwrite;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  wb_valid, wb_regwrite;
  logic [REG_ADDR_W-1:0] wb_rd;

  logic     taken, load_use, mem_fwd, wb_fwd;
  fwd_sel_e sel_a, sel_b;

  always_comb begin
    taken    = ex_branch_taken & ex_valid;
    load_use = ex_valid & ex_memread & (ex_rd != '0) &
               ((ex_rd == id_rs1) | (id_use_rs2 & (ex_rd == id_rs2)));
    flush    = taken;
    stall    = ~taken & id_valid & load_use;
  end

  // Younger producer (MEM) is checked first so it wins over WB.
  always_comb begin
    mem_fwd = mem_valid & mem_regwrite & (mem_rd != '0);
    wb_fwd  = wb_valid & wb_regwrite & (wb_rd != '0);
    sel_a   = SEL_RF;
    sel_b   = SEL_RF;
    if (ex_valid) begin
      if (mem_fwd && (mem_rd == ex_rs1))     sel_a = SEL_MEM;
      else if (wb_fwd && (wb_rd == ex_rs1))  sel_a = SEL_WB;
      if (ex_use_rs2) begin
        if (mem_fwd && (mem_rd == ex_rs2))    sel_b = SEL_MEM;
        else if (wb_fwd && (wb_rd == ex_rs2)) sel_b = SEL_WB;
      end
    end
  end

  assign fwd_a_sel = sel_a;
  assign fwd_b_sel = sel_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_use_rs2   <= 1'b0;
      ex_rd        <= '0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      mem_valid    <= 1'b0;
      mem_rd       <= '0;
      mem_regwrite <= 1'b0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_regwrite  <= 1'b0;
    end else begin
      wb_valid     <= mem_valid;
      wb_rd        <= mem_rd;
      wb_regwrite  <= mem_regwrite;
      mem_valid    <= ex_valid;
      mem_rd       <= ex_rd;
      mem_regwrite <= ex_regwrite;
      ex_valid     <= id_valid & ~stall & ~flush;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
      ex_use_rs2   <= id_use_rs2;
      ex_rd        <= id_rd;
      ex_regwrite  <= id_regwrite;
      ex_memread   <= id_memread;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Saturating counters: hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule
